// File: rtl/e15_core_param.sv
// E15 core, parametrised: run/halt FSM, program load port,
// carry flag with jc/jnc/hlt, and a debug register read port.
module e15_core_param #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int PC_W = 4,
  localparam int INSTR_W = 4 + 2 * REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [PC_W-1:0]    pc_out,
  output logic               zflag,
  output logic               cflag,
  output logic               running,
  output logic               halted
);

  localparam int NREG = 1 << REG_AW;
  localparam int DEPTH = 1 << PC_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t state;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0]  rf [NREG];
  logic [PC_W-1:0]    pc;
  logic               zf;
  logic               cf;

  logic [INSTR_W-1:0] instr;
  logic [3:0]         op;
  logic [REG_AW-1:0]  src;
  logic [REG_AW-1:0]  dst;
  logic [DATA_W-1:0]  imm;

  assign instr = mem[pc];
  assign op = instr[INSTR_W-1 -: 4];
  assign src = instr[DATA_W+REG_AW +: REG_AW];
  assign dst = instr[DATA_W +: REG_AW];
  assign imm = instr[DATA_W-1:0];

  logic isHlt;
  logic isBr;
  logic isMov;
  logic isMovi;
  logic isAlu;
  logic wb;

  assign isHlt = (op == 4'b0001);
  assign isBr = !op[3] && !isHlt && (op[2:1] != 2'b11);
  assign isMov = (op == 4'b1000);
  assign isMovi = (op == 4'b1001);
  assign isAlu = op[3] && (op[2:1] != 2'b00);
  // cmp/cmpi (11x) only touch the flags
  assign wb = isAlu && (op[2:1] != 2'b11);

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (op[2:0])
      3'b000:  taken = 1'b1;
      3'b010:  taken = zf;
      3'b011:  taken = !zf;
      3'b100:  taken = cf;
      3'b101:  taken = !cf;
      default: taken = 1'b0;
    endcase
  end

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              carry;

  assign opA = op[0] ? imm : rf[src];
  assign opB = rf[dst];
  // subtract as B + ~A + 1 so carry reads as "no borrow"
  assign sum = op[2]
    ? {1'b0, opB} + {1'b0, ~opA} + (DATA_W+1)'(1)
    : {1'b0, opB} + {1'b0, opA};
  assign res = sum[DATA_W-1:0];
  assign carry = sum[DATA_W];

  logic [PC_W-1:0] pcInc;
  logic [PC_W-1:0] pcJmp;

  assign pcInc = pc + PC_W'(1);
  assign pcJmp = pc + imm[PC_W-1:0];

  always_ff @(posedge clk) begin
    if (prog_we && state != RUN) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      zf <= 1'b0;
      cf <= 1'b0;
      running <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            state <= RUN;
            pc <= '0;
            zf <= 1'b0;
            cf <= 1'b0;
            running <= 1'b1;
            halted <= 1'b0;
          end
        end
        RUN: begin
          unique case (1'b1)
            isHlt: begin
              state <= HALT;
              running <= 1'b0;
              halted <= 1'b1;
            end
            isBr: begin
              pc <= taken ? pcJmp : pcInc;
            end
            isMov: begin
              rf[dst] <= rf[src];
              pc <= pcInc;
            end
            isMovi: begin
              rf[dst] <= imm;
              pc <= pcInc;
            end
            isAlu: begin
              if (wb) begin
                rf[dst] <= res;
              end
              zf <= (res == '0);
              cf <= carry;
              pc <= pcInc;
            end
            default: begin
              pc <= pcInc;
            end
          endcase
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_data = rf[dbg_sel];
  assign pc_out = pc;
  assign zflag = zf;
  assign cflag = cf;

endmodule

// File: tb/tb_e15_core_param.sv
// Bench for e15_core_param: ISA-level reference model,
// per-cycle compare, and directed programs with literal checks.
module tb_e15_core_param;

  localparam int OP_JMP = 0;
  localparam int OP_HLT = 1;
  localparam int OP_JZ = 2;
  localparam int OP_JNZ = 3;
  localparam int OP_JC = 4;
  localparam int OP_JNC = 5;
  localparam int OP_NOP = 6;
  localparam int OP_MOV = 8;
  localparam int OP_MOVI = 9;
  localparam int OP_ADD = 10;
  localparam int OP_ADDI = 11;
  localparam int OP_SUB = 12;
  localparam int OP_SUBI = 13;
  localparam int OP_CMP = 14;
  localparam int OP_CMPI = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [1:0]  dbg_sel = '0;
  logic [7:0]  dbg_data;
  logic [3:0]  pc_out;
  logic        zflag;
  logic        cflag;
  logic        running;
  logic        halted;

  e15_core_param #(
    .DATA_W(8),
    .REG_AW(2),
    .PC_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .dbg_sel(dbg_sel),
    .dbg_data(dbg_data),
    .pc_out(pc_out),
    .zflag(zflag),
    .cflag(cflag),
    .running(running),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pc;
    logic       z;
    logic       c;
    logic       halt;
    logic       wr;
    logic [1:0] wa;
    logic [7:0] wd;
  } step_t;

  logic [15:0]      mMem [16];
  logic [3:0][7:0]  mReg;
  logic [3:0]       mPc;
  logic             mZ;
  logic             mC;
  logic             mRun;
  logic             mHalt;
  step_t            nx;

  function automatic step_t modelStep(
    input logic [15:0] ins,
    input logic [3:0] pc,
    input logic z,
    input logic c,
    input logic [3:0][7:0] regs
  );
    step_t n;
    int op, src, dst, imm, a, b, r;
    bit tk;
    op = int'(ins[15:12]);
    src = int'(ins[11:10]);
    dst = int'(ins[9:8]);
    imm = int'(ins[7:0]);
    n.pc = 4'((int'(pc) + 1) % 16);
    n.z = z;
    n.c = c;
    n.halt = 1'b0;
    n.wr = 1'b0;
    n.wa = 2'(dst);
    n.wd = '0;
    tk = (op == OP_JMP) || (op == OP_JZ && z)
      || (op == OP_JNZ && !z) || (op == OP_JC && c)
      || (op == OP_JNC && !c);
    if (op == OP_HLT) begin
      n.pc = pc;
      n.halt = 1'b1;
    end else if (op <= OP_JNC) begin
      if (tk) n.pc = 4'((int'(pc) + imm) % 16);
    end else if (op == OP_MOV) begin
      n.wr = 1'b1;
      n.wd = regs[src];
    end else if (op == OP_MOVI) begin
      n.wr = 1'b1;
      n.wd = 8'(imm);
    end else if (op >= OP_ADD) begin
      a = (op % 2 == 1) ? imm : int'(regs[src]);
      b = int'(regs[dst]);
      if (op <= OP_ADDI) begin
        r = b + a;
        n.c = (r >= 256);
      end else begin
        r = b - a;
        n.c = (b >= a);
      end
      r = (r + 256) % 256;
      n.z = (r == 0);
      n.wr = (op <= OP_SUBI);
      n.wd = 8'(r);
    end
    return n;
  endfunction

  always_comb nx = modelStep(mMem[mPc], mPc, mZ, mC, mReg);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPc <= '0;
      mZ <= 1'b0;
      mC <= 1'b0;
      mRun <= 1'b0;
      mHalt <= 1'b0;
      mReg <= '0;
    end else begin
      if (prog_we && !mRun) mMem[prog_addr] <= prog_data;
      if (!mRun && start) begin
        mRun <= 1'b1;
        mHalt <= 1'b0;
        mPc <= '0;
        mZ <= 1'b0;
        mC <= 1'b0;
      end else if (mRun) begin
        mPc <= nx.pc;
        mZ <= nx.z;
        mC <= nx.c;
        if (nx.wr) mReg[nx.wa] <= nx.wd;
        if (nx.halt) begin
          mRun <= 1'b0;
          mHalt <= 1'b1;
        end
      end
    end
  end

  int nChecks = 0;
  int nFails = 0;
  bit done = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int src,
                                      input int dst, input int imm);
    return {4'(op), 2'(src), 2'(dst), 8'(imm)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    dbg_sel = dbg_sel + 2'd1;
  endtask

  task automatic load(input int addr, input logic [15:0] data);
    prog_we = 1'b1;
    prog_addr = 4'(addr);
    prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic startRun();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic runUntilHalt(input int maxCycles);
    int n;
    n = 0;
    while (!halted && n < maxCycles) begin
      tick();
      n++;
    end
    check("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic readReg(input int idx, input string name,
                         input int exp);
    dbg_sel = 2'(idx);
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  task automatic countToHalt(input string name, input int exp);
    int n;
    n = 0;
    while (!halted && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(exp));
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!done) begin
          check("pc_out", 32'(pc_out), 32'(mPc));
          check("zflag", 32'(zflag), 32'(mZ));
          check("cflag", 32'(cflag), 32'(mC));
          check("running", 32'(running), 32'(mRun));
          check("halted", 32'(halted), 32'(mHalt));
          check("dbg_data", 32'(dbg_data), 32'(mReg[dbg_sel]));
        end
      end
    join_none

    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_run", 32'(running), 32'd0);
    check("rst_halt", 32'(halted), 32'd0);

    // arithmetic, carry out, compare and register forms
    load(0, enc(OP_MOVI, 0, 0, 200));
    load(1, enc(OP_ADDI, 0, 0, 100));
    load(2, enc(OP_CMPI, 0, 0, 44));
    load(3, enc(OP_JZ, 0, 0, 2));
    load(4, enc(OP_HLT, 0, 0, 0));
    load(5, enc(OP_MOV, 0, 3, 0));
    load(6, enc(OP_ADD, 0, 3, 0));
    load(7, enc(OP_CMP, 0, 3, 0));
    load(8, enc(OP_SUB, 3, 0, 0));
    load(9, enc(OP_HLT, 0, 0, 0));
    startRun();
    check("t2_running", 32'(running), 32'd1);
    tick();
    tick();
    readReg(0, "t2_addi_r0", 44);
    check("t2_addi_c", 32'(cflag), 32'd1);
    check("t2_addi_z", 32'(zflag), 32'd0);
    tick();
    readReg(0, "t2_cmpi_r0", 44);
    check("t2_cmpi_z", 32'(zflag), 32'd1);
    check("t2_cmpi_c", 32'(cflag), 32'd1);
    runUntilHalt(50);
    check("t2_pc", 32'(pc_out), 32'd9);
    readReg(0, "t2_sub_r0", 212);
    readReg(3, "t2_add_r3", 88);
    check("t2_sub_c", 32'(cflag), 32'd0);

    // borrow, jnc taken, jc not taken
    load(0, enc(OP_MOVI, 0, 1, 3));
    load(1, enc(OP_SUBI, 0, 1, 5));
    load(2, enc(OP_JNC, 0, 0, 2));
    load(3, enc(OP_HLT, 0, 0, 0));
    load(4, enc(OP_JC, 0, 0, 3));
    load(5, enc(OP_HLT, 0, 0, 0));
    startRun();
    runUntilHalt(50);
    check("t3_pc", 32'(pc_out), 32'd5);
    readReg(1, "t3_r1", 254);
    check("t3_c", 32'(cflag), 32'd0);
    check("t3_z", 32'(zflag), 32'd0);

    // countdown loop
    load(0, enc(OP_MOVI, 0, 2, 5));
    load(1, enc(OP_SUBI, 0, 2, 1));
    load(2, enc(OP_JNZ, 0, 0, -1));
    load(3, enc(OP_HLT, 0, 0, 0));
    startRun();
    countToHalt("t4_cycles", 12);
    check("t4_pc", 32'(pc_out), 32'd3);
    readReg(2, "t4_r2", 0);
    check("t4_z", 32'(zflag), 32'd1);

    // asynchronous reset in the middle of the loop
    startRun();
    repeat (4) tick();
    #2;
    dbg_sel = 2'd2;
    rst = 1'b1;
    #1;
    check("t1_pc", 32'(pc_out), 32'd0);
    check("t1_r2", 32'(dbg_data), 32'd0);
    check("t1_z", 32'(zflag), 32'd0);
    check("t1_c", 32'(cflag), 32'd0);
    check("t1_running", 32'(running), 32'd0);
    check("t1_halted", 32'(halted), 32'd0);
    repeat (4) tick();
    rst = 1'b0;
    startRun();
    countToHalt("t1_rerun_cycles", 12);

    // program writes ignored while running
    load(0, enc(OP_NOP, 0, 0, 0));
    load(1, enc(OP_NOP, 0, 0, 0));
    load(2, enc(OP_NOP, 0, 0, 0));
    load(3, enc(OP_HLT, 0, 0, 0));
    startRun();
    load(3, enc(OP_MOVI, 0, 3, 99));
    runUntilHalt(20);
    check("t5_guard_pc", 32'(pc_out), 32'd3);
    readReg(3, "t5_guard_r3", 0);
    load(0, enc(OP_MOVI, 0, 3, 42));
    load(1, enc(OP_HLT, 0, 0, 0));
    startRun();
    runUntilHalt(20);
    check("t5_new_pc", 32'(pc_out), 32'd1);
    readReg(3, "t5_new_r3", 42);
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = enc(OP_HLT, 0, 0, 0);
    start = 1'b1;
    tick();
    prog_we = 1'b0;
    start = 1'b0;
    tick();
    check("t5_same_halted", 32'(halted), 32'd1);
    check("t5_same_pc", 32'(pc_out), 32'd0);

    // pc wraps from 15 to 0
    load(0, enc(OP_JNC, 0, 0, 14));
    load(1, enc(OP_HLT, 0, 0, 0));
    load(14, enc(OP_CMPI, 0, 0, 0));
    load(15, enc(OP_NOP, 0, 0, 0));
    startRun();
    tick();
    check("t6_pc14", 32'(pc_out), 32'd14);
    tick();
    check("t6_pc15", 32'(pc_out), 32'd15);
    tick();
    check("t6_wrap_pc", 32'(pc_out), 32'd0);
    check("t6_wrap_run", 32'(running), 32'd1);
    runUntilHalt(20);
    check("t6_pc", 32'(pc_out), 32'd1);
    check("t6_z", 32'(zflag), 32'd1);
    check("t6_c", 32'(cflag), 32'd1);

    tick();
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
